// File: rtl/cfa_phase_scheduler.sv
// Raster/CFA-phase tracker and tag delay line for the demosaic interpolation datapath.
// Tags ride a dp_en-gated shift register matching the datapath latency, so output muxing stays aligned.
module cfa_phase_scheduler #(
  parameter int DataBitWidth = 12,
  parameter int ImgWidth     = 640,
  parameter int ImgHeight    = 480,
  parameter int PipeLatency  = 3,
  parameter int BayerPattern = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  output logic                         dp_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_phase,
  output logic                         out_border,
  output logic [$clog2(ImgHeight)-1:0] out_row,
  output logic [$clog2(ImgWidth)-1:0]  out_col,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic                         frame_err
);

  localparam int RW = $clog2(ImgHeight);
  localparam int CW = $clog2(ImgWidth);
  localparam logic [RW-1:0] LastRow = RW'(ImgHeight - 1);
  localparam logic [CW-1:0] LastCol = CW'(ImgWidth - 1);
  localparam logic [1:0]    Pattern = 2'(BayerPattern);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // The pixel width only describes the attached datapath; nothing here is sized by it.
  if (DataBitWidth < 1) begin : g_bad_width
  end

  typedef struct packed {
    logic          valid;
    logic [1:0]    phase;
    logic          border;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          sof;
    logic          eof;
  } tag_t;

  logic [1:0]    r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_frame_err;
  tag_t          r_pipe [PipeLatency];

  logic          w_accept;
  logic          w_restart;
  logic          w_insert;
  logic          w_last;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  tag_t          w_tag;
  tag_t          w_tail;

  assign w_tail    = r_pipe[PipeLatency-1];
  assign dp_en     = ~w_tail.valid | out_ready;
  assign in_ready  = dp_en & (r_state != StFlush);
  assign w_accept  = in_valid & in_ready;
  assign w_restart = w_accept & in_sof;
  // Outside RUN only a start-of-frame beat is allowed into the pipe.
  assign w_insert  = w_accept & ((r_state == StRun) | in_sof);
  assign w_row     = w_restart ? '0 : r_row;
  assign w_col     = w_restart ? '0 : r_col;
  assign w_last    = (w_row == LastRow) && (w_col == LastCol);

  always_comb begin
    w_tag = '0;
    if (w_insert) begin
      w_tag.valid  = 1'b1;
      w_tag.phase  = Pattern ^ {w_row[0], w_col[0]};
      w_tag.border = (w_row == '0) || (w_row == LastRow) || (w_col == '0) || (w_col == LastCol);
      w_tag.row    = w_row;
      w_tag.col    = w_col;
      w_tag.sof    = (w_row == '0) && (w_col == '0);
      w_tag.eof    = w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_row       <= '0;
      r_col       <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < PipeLatency; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_frame_err <= w_restart & (r_state == StRun);

      if (dp_en) begin
        r_pipe[0] <= w_tag;
        for (int i = 1; i < PipeLatency; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end

      if (w_insert) begin
        if (w_last) begin
          r_row <= '0;
          r_col <= '0;
        end else if (w_col == LastCol) begin
          r_row <= w_row + 1'b1;
          r_col <= '0;
        end else begin
          r_row <= w_row;
          r_col <= w_col + 1'b1;
        end
      end

      // FLUSH holds off new input until the eof beat has actually left the block.
      case (r_state)
        StIdle: begin
          if (w_insert) r_state <= w_last ? StFlush : StRun;
        end
        StRun: begin
          if (w_insert && w_last) r_state <= StFlush;
        end
        StFlush: begin
          if (w_tail.valid && out_ready && w_tail.eof) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_valid  = w_tail.valid;
  assign out_phase  = w_tail.phase;
  assign out_border = w_tail.border;
  assign out_row    = w_tail.row;
  assign out_col    = w_tail.col;
  assign out_sof    = w_tail.sof;
  assign out_eof    = w_tail.eof;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_cfa_phase_scheduler.sv
// Scoreboard bench for cfa_phase_scheduler on a 4x4 frame, two instances (RGGB and BGGR) sharing stimulus.
// The driver pushes expected tags on accept; a separate monitor pops and compares as beats leave.
module tb_cfa_phase_scheduler;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int Lat = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready,  dp_en,  out_valid,  out_border,  out_sof,  out_eof,  frame_err;
  logic [1:0] out_phase, out_row, out_col;
  logic       in_ready3, dp_en3, out_valid3, out_border3, out_sof3, out_eof3, frame_err3;
  logic [1:0] out_phase3, out_row3, out_col3;

  cfa_phase_scheduler #(.DataBitWidth(12), .ImgWidth(W), .ImgHeight(H),
                        .PipeLatency(Lat), .BayerPattern(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .dp_en(dp_en), .out_valid(out_valid), .out_ready(out_ready), .out_phase(out_phase),
    .out_border(out_border), .out_row(out_row), .out_col(out_col), .out_sof(out_sof),
    .out_eof(out_eof), .frame_err(frame_err)
  );

  cfa_phase_scheduler #(.DataBitWidth(12), .ImgWidth(W), .ImgHeight(H),
                        .PipeLatency(Lat), .BayerPattern(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_sof(in_sof),
    .dp_en(dp_en3), .out_valid(out_valid3), .out_ready(out_ready), .out_phase(out_phase3),
    .out_border(out_border3), .out_row(out_row3), .out_col(out_col3), .out_sof(out_sof3),
    .out_eof(out_eof3), .frame_err(frame_err3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int row;
    int col;
    int ph0;
    int ph3;
    int border;
    int sof;
    int eof;
    int accCyc;
    bit latChk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad = 0;
  int mState = 0;
  int mRow = 0;
  int mCol = 0;
  int errPending = 0;

  // Hand-derived phase codes indexed by {row[0],col[0]}: RGGB and BGGR.
  int ph0Table[4] = '{0, 1, 2, 3};
  int ph3Table[4] = '{3, 2, 1, 0};

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic stepCheckErr();
    checkOutput("frame_err", int'(frame_err), errPending);
    errPending = 0;
  endtask

  task automatic modelAccept(input bit sof, input int accCyc, input bit latChk);
    exp_t e;
    int r, c;
    errPending = (sof && mState == 1) ? 1 : 0;
    if (!(mState == 1 || sof)) return;
    r = sof ? 0 : mRow;
    c = sof ? 0 : mCol;
    e.row    = r;
    e.col    = c;
    e.ph0    = ph0Table[(r % 2) * 2 + (c % 2)];
    e.ph3    = ph3Table[(r % 2) * 2 + (c % 2)];
    e.border = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 1 : 0;
    e.sof    = (r == 0 && c == 0) ? 1 : 0;
    e.eof    = (r == H - 1 && c == W - 1) ? 1 : 0;
    e.accCyc = accCyc;
    e.latChk = latChk;
    q0.push_back(e);
    q1.push_back(e);
    if (e.eof == 1) begin
      mState = 0;
      mRow = 0;
      mCol = 0;
    end else begin
      mState = 1;
      mRow = (c == W - 1) ? r + 1 : r;
      mCol = (c == W - 1) ? 0 : c + 1;
    end
  endtask

  task automatic applyStimulus(input bit sof, input bit latChk);
    for (int tries = 0; tries < 50; tries++) begin
      @(negedge clk);
      stepCheckErr();
      in_valid = 1'b1;
      in_sof   = sof;
      #1;
      if (in_ready) begin
        modelAccept(sof, cyc, latChk);
        return;
      end
    end
    checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    stepCheckErr();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      idleCycle();
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    checkOutput("drain_queue", q0.size() + q1.size(), 0);
    idleCycle();
    checkOutput("idle_in_ready", int'(in_ready), 1);
  endtask

  task automatic sendFrame(input int firstIdx, input int lastIdx, input bit latChk);
    for (int i = firstIdx; i <= lastIdx; i++) begin
      applyStimulus(i == 0, latChk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (q0.size() == 0) begin
          checkOutput("dut0_unexpected_beat", 1, 0);
        end else if (out_ready) begin
          e = q0.pop_front();
          checkOutput("dut0_row",    int'(out_row),    e.row);
          checkOutput("dut0_col",    int'(out_col),    e.col);
          checkOutput("dut0_phase",  int'(out_phase),  e.ph0);
          checkOutput("dut0_border", int'(out_border), e.border);
          checkOutput("dut0_sof",    int'(out_sof),    e.sof);
          checkOutput("dut0_eof",    int'(out_eof),    e.eof);
          if (e.latChk) checkOutput("dut0_latency", cyc - e.accCyc, Lat);
        end
      end
      if (out_valid3) begin
        if (q1.size() == 0) begin
          checkOutput("dut3_unexpected_beat", 1, 0);
        end else if (out_ready) begin
          e = q1.pop_front();
          checkOutput("dut3_row",    int'(out_row3),    e.row);
          checkOutput("dut3_col",    int'(out_col3),    e.col);
          checkOutput("dut3_phase",  int'(out_phase3),  e.ph3);
          checkOutput("dut3_border", int'(out_border3), e.border);
          checkOutput("dut3_eof",    int'(out_eof3),    e.eof);
          if (e.latChk) checkOutput("dut3_latency", cyc - e.accCyc, Lat);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int flushReady[4] = '{0, 0, 0, 1};
    int snapRow, snapCol, snapPhase;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    checkOutput("reset_in_ready",  int'(in_ready),  1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sof",   int'(out_sof),   0);
    checkOutput("reset_out_eof",   int'(out_eof),   0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    rst = 1'b1;

    // Beats before any sof are dropped; the monitor flags any that reach the output.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Continuous 4x4 frame, then watch in_ready come back exactly when eof leaves.
    sendFrame(0, 15, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("flush_in_ready", int'(in_ready), flushReady[i]);
    end
    checkOutput("frameA_all_out", q0.size(), 0);

    // Backpressure: five cycles of out_ready=0 with the pipe full.
    sendFrame(0, 5, 1'b0);
    snapRow = 0;
    snapCol = 0;
    snapPhase = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stepCheckErr();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sof    = 1'b0;
      #1;
      checkOutput("stall_dp_en",     int'(dp_en),     0);
      checkOutput("stall_in_ready",  int'(in_ready),  0);
      checkOutput("stall_out_valid", int'(out_valid), 1);
      if (i == 0) begin
        snapRow   = int'(out_row);
        snapCol   = int'(out_col);
        snapPhase = int'(out_phase);
      end else begin
        checkOutput("stall_row_hold",   int'(out_row),   snapRow);
        checkOutput("stall_col_hold",   int'(out_col),   snapCol);
        checkOutput("stall_phase_hold", int'(out_phase), snapPhase);
      end
    end
    @(negedge clk);
    stepCheckErr();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    sendFrame(6, 15, 1'b0);
    drain();

    // sof arrives at (2,1): frame restarts there and frame_err pulses once.
    sendFrame(0, 8, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1);
    end
    drain();

    // Reset while flushing with two beats in flight: the eof beat must never appear.
    sendFrame(0, 15, 1'b1);
    idleCycle();
    @(negedge clk);
    stepCheckErr();
    rst = 1'b0;
    @(negedge clk);
    stepCheckErr();
    #3;
    checkOutput("rst_flush_out_valid", int'(out_valid), 0);
    checkOutput("rst_flush_in_ready",  int'(in_ready),  1);
    checkOutput("rst_flush_out_eof",   int'(out_eof),   0);
    q0.delete();
    q1.delete();
    mState = 0;
    mRow = 0;
    mCol = 0;
    rst = 1'b1;
    repeat (6) idleCycle();
    checkOutput("final_queue_empty", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
